i2s_rx_tdm: RTL and testbench
=============================

# i2s_rx_tdm

Parametrised I2S/TDM serial-audio receiver. It replaces the fixed stereo 24-in-32 receiver at the ADC input of the pedal datapath. It accepts N slots per frame in I2S or left-justified format, runs entirely in the system clock domain, and buffers the extracted samples in a small FIFO. Samples leave on a vld/ok stream, one per slot, tagged with slot index and end-of-frame.

## Interface
- `SAMPLE_WIDTH`, 24: sample bits kept per slot, MSB-first; 1..SLOT_WIDTH.
- `SLOT_WIDTH`, 32: sclk periods per slot; 8..64.
- `NUM_SLOTS`, 2: slots per frame. 2 = stereo (lrck as word select); >2 = TDM (lrck as frame sync); max 16.
- `FMT_LJ`, 0: 0 = I2S (MSB one sclk after the frame edge); 1 = left-justified (MSB on the first sclk after the edge).
- `FIFO_DEPTH`, 8: sample FIFO entries; power of two, ≥2.
- `clk` in 1: system clock; must be ≥4× sclk.
- `rst_n` in 1: asynchronous, active-low reset.
- `sclk` in 1: serial bit clock, asynchronous.
- `lrck` in 1: word select / frame sync, asynchronous.
- `sdi` in 1: serial data, asynchronous.
- `m_data` out SAMPLE_WIDTH: sample, two's complement.
- `m_slot` out $clog2(NUM_SLOTS): slot index of `m_data`.
- `m_last` out 1: marks slot NUM_SLOTS-1.
- `m_vld` out 1: sample valid.
- `m_ok` in 1: consumer accepts. A transfer happens when `m_vld & m_ok`.
- `ovf` out 1: sticky, set when a sample is dropped because the FIFO is full.
- `ovf_clr` in 1: clears `ovf` (1-cycle pulse).
- `frame_err` out 1: 1-cycle pulse on a framing error (only with the macro, see Configuration).

## Operation
- Input conditioning:
  - `sclk`, `lrck` and `sdi` each pass through a 2-flop synchroniser.
  - `sclk` rising edge → `bit_stb`, a 1-cycle strobe.
  - `lrck` and `sdi` are sampled at `bit_stb`.
- Frame edge is detected at `bit_stb`:
  - NUM_SLOTS=2: `lrck` 1→0. Slot 0 = left (lrck low), slot 1 = right.
  - NUM_SLOTS>2: `lrck` 0→1.
- FSM states:
  - SYNC (reset state): ignores data. On a frame edge it loads the bit/slot counters and goes to RUN.
  - RUN: on each `bit_stb`, the bit counter increments and wraps at SLOT_WIDTH-1, which advances the slot counter.
- Bit alignment:
  - I2S: the bit sampled on the frame-edge strobe is the previous frame's LSB padding and is discarded; the MSB is the next strobe.
  - LJ: the bit sampled on the frame-edge strobe is the MSB.
- Capture:
  - Bits 0..SAMPLE_WIDTH-1 of each slot are shifted into the shift register; the remaining bits are ignored.
  - After bit SAMPLE_WIDTH-1, {slot, last, sample} is pushed to the FIFO.
- Overflow: a push while the FIFO is full drops the new sample; FIFO contents are unchanged and `ovf` is set.
- `ovf` behaviour: `ovf_clr` has priority over a simultaneous set. `ovf` stays high until cleared.
- NUM_SLOTS=2: a frame edge in RUN (normal case, the count has completed) restarts slot 0 with no error.
- Reset mid-frame:
  - The FIFO is emptied, the FSM goes to SYNC, and the partial sample is lost.
  - Capture resumes only at the next frame edge.

## Timing
- Reset values: `m_vld`=0, `m_data`=0, `m_slot`=0, `m_last`=0, `ovf`=0, `frame_err`=0; FIFO empty; FSM in SYNC.
- Latency: `bit_stb` for the sample's last bit at cycle N → FIFO push at N+1 → `m_vld` at N+2 if the FIFO was empty. Pin-to-`m_vld` is ≤5 clk.
- The FIFO is show-ahead: `m_data`, `m_slot` and `m_last` are stable while `m_vld & ~m_ok`.
- Simultaneous push and pop when full: the pop frees space and the push is accepted; no overflow.
- Back-to-back pops are supported: `m_vld` can stay high every cycle.

## Configuration
- `I2S_RX_FRAME_CHECK_EN` defined:
  - In RUN, a frame edge arriving while (slot,bit) ≠ (NUM_SLOTS-1, SLOT_WIDTH-1) pulses `frame_err`, discards the partial sample, and restarts at slot 0.
  - Counting past the end of the frame without a frame edge pulses `frame_err` and returns the FSM to SYNC.
- Undefined:
  - No checking; `frame_err` is tied 0.
  - Each frame edge simply reloads the counters.
  - Strobes after slot NUM_SLOTS-1 completes are ignored until the next frame edge.

## Structure
- Shared package `i2s_pkg`: format encoding constants (`I2S_FMT_I2S`, `I2S_FMT_LJ`) and the `i2s_rx_state_e` enum {SYNC, RUN}.
- Sub-module `sample_fifo`:
  - Parametrised width/depth, synchronous, show-ahead.
  - Ports `full`/`empty`; wr-when-full ignored.
  - Reusable for the TX side.

## Test plan
- Stereo I2S, 24/32: left=0x123456, right=0xABCDEF, `m_ok`=1 → two transfers: (0x123456, slot 0, last 0), (0xABCDEF, slot 1, last 1).
- Left-justified, NUM_SLOTS=8, SAMPLE_WIDTH=16, SLOT_WIDTH=32, slot k = 0x1000+k → 8 samples, slots 0..7 in order, `m_last` only on 0x1007.
- FIFO_DEPTH=8, `m_ok`=0 for 12 samples → 8 retained (first 8 in order), `ovf`=1. Then `ovf_clr` → `ovf`=0.
- Reset asserted at bit 10 of slot 0 → no output from that frame; first output is slot 0 of the next full frame.
- With `I2S_RX_FRAME_CHECK_EN`: an early frame edge at slot 1 bit 5 → one `frame_err` pulse, no slot-1 sample, next frame received correctly.
- Random `m_ok` throttling over 100 frames at maximum sclk rate → output sequence matches the reference model, no `ovf`.

Source files
------------

// File: rtl/i2s_pkg.sv
// Shared constants and types for the I2S/TDM serial-audio datapath.
package i2s_pkg;
    localparam logic I2S_FMT_I2S = 1'b0;
    localparam logic I2S_FMT_LJ  = 1'b1;

    typedef enum logic [0:0] {
        SYNC = 1'b0,
        RUN  = 1'b1
    } i2s_rx_state_e;
endpackage

// File: rtl/sample_fifo.sv
// Synchronous show-ahead FIFO; a write while full is dropped unless a read frees a slot the same cycle.
module sample_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic             wr_en;
    logic             rd_en;

    assign empty     = (wr_ptr_q == rd_ptr_q);
    assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign rd_en     = rd_i & ~empty;
    assign wr_en     = wr_i & (~full | rd_en);
    // Zero when empty so the head reads as 0 out of reset.
    assign rd_data_o = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            if (rd_en) rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
    end
endmodule

// File: rtl/i2s_rx_tdm.sv
// I2S / left-justified / TDM receiver in the system clock domain, samples buffered in a show-ahead FIFO.
// Define I2S_RX_FRAME_CHECK_EN to report framing errors on frame_err and resync on overrun.
module i2s_rx_tdm
    import i2s_pkg::*;
#(
    parameter int SAMPLE_WIDTH = 24,
    parameter int SLOT_WIDTH   = 32,
    parameter int NUM_SLOTS    = 2,
    parameter int FMT_LJ       = 0,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         sclk,
    input  logic                         lrck,
    input  logic                         sdi,
    output logic [SAMPLE_WIDTH-1:0]      m_data,
    output logic [$clog2(NUM_SLOTS)-1:0] m_slot,
    output logic                         m_last,
    output logic                         m_vld,
    input  logic                         m_ok,
    output logic                         ovf,
    input  logic                         ovf_clr,
    output logic                         frame_err
);
    localparam int   SLOT_W  = $clog2(NUM_SLOTS);
    localparam int   BIT_W   = $clog2(SLOT_WIDTH);
    localparam int   ENTRY_W = SLOT_W + 1 + SAMPLE_WIDTH;
    localparam bit   LJ      = (FMT_LJ == int'(I2S_FMT_LJ));
    localparam logic LRCK_IDLE = (NUM_SLOTS > 2) ? 1'b1 : 1'b0;
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_SLOTS - 1);
    localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(SLOT_WIDTH - 1);
    localparam logic [BIT_W-1:0]  SMP_LAST  = BIT_W'(SAMPLE_WIDTH - 1);
    localparam logic [BIT_W:0]    SMP_END   = (BIT_W+1)'(SAMPLE_WIDTH);

    logic [1:0] sclk_sync_q, lrck_sync_q, sdi_sync_q;
    logic       sclk_prev_q, lrck_last_q;
    logic       bit_stb, frame_edge;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync_q <= '0;
            lrck_sync_q <= '0;
            sdi_sync_q  <= '0;
            sclk_prev_q <= 1'b0;
            lrck_last_q <= LRCK_IDLE;
        end else begin
            sclk_sync_q <= {sclk_sync_q[0], sclk};
            lrck_sync_q <= {lrck_sync_q[0], lrck};
            sdi_sync_q  <= {sdi_sync_q[0], sdi};
            sclk_prev_q <= sclk_sync_q[1];
            if (bit_stb) lrck_last_q <= lrck_sync_q[1];
        end
    end

    assign bit_stb    = sclk_sync_q[1] & ~sclk_prev_q;
    assign frame_edge = bit_stb & ((NUM_SLOTS > 2) ? (~lrck_last_q & lrck_sync_q[1])
                                                   : (lrck_last_q & ~lrck_sync_q[1]));

    i2s_rx_state_e             state_q, state_d;
    logic [BIT_W-1:0]          bit_q, bit_d, cap_bit;
    logic [SLOT_W-1:0]         slot_q, slot_d, cap_slot;
    logic                      done_q, done_d, cap, at_end;
    logic [SAMPLE_WIDTH-1:0]   shift_q, shift_d;
    logic                      push_q, push_d;
    logic [ENTRY_W-1:0]        push_data_q, push_data_d;
`ifdef I2S_RX_FRAME_CHECK_EN
    logic                      err_q, err_d;
`endif

    // The end-of-frame position differs: I2S sees the edge on the padding bit, LJ one strobe after the last bit.
    assign at_end = LJ ? done_q : ((slot_q == LAST_SLOT) && (bit_q == LAST_BIT));

    always_comb begin
        state_d     = state_q;
        bit_d       = bit_q;
        slot_d      = slot_q;
        done_d      = done_q;
        shift_d     = shift_q;
        push_d      = 1'b0;
        push_data_d = push_data_q;
        cap         = 1'b0;
        cap_bit     = bit_q;
        cap_slot    = slot_q;
`ifdef I2S_RX_FRAME_CHECK_EN
        err_d       = 1'b0;
`endif
        if (frame_edge) begin
`ifdef I2S_RX_FRAME_CHECK_EN
            err_d = (state_q == RUN) && !at_end;
`endif
            state_d = RUN;
            slot_d  = '0;
            done_d  = 1'b0;
            if (LJ) begin
                cap      = 1'b1;
                cap_bit  = '0;
                cap_slot = '0;
                bit_d    = BIT_W'(1);
            end else begin
                bit_d    = '0;
            end
        end else if (bit_stb && (state_q == RUN)) begin
            if (!at_end) begin
                cap = 1'b1;
                if (bit_q == LAST_BIT) begin
                    bit_d = '0;
                    if (slot_q == LAST_SLOT) done_d = 1'b1;
                    else                     slot_d = slot_q + SLOT_W'(1);
                end else begin
                    bit_d = bit_q + BIT_W'(1);
                end
            end
`ifdef I2S_RX_FRAME_CHECK_EN
            else begin
                err_d   = 1'b1;
                state_d = SYNC;
            end
`endif
        end

        if (cap && ({1'b0, cap_bit} < SMP_END)) begin
            shift_d = SAMPLE_WIDTH'({shift_q, sdi_sync_q[1]});
            if (cap_bit == SMP_LAST) begin
                push_d      = 1'b1;
                push_data_d = {cap_slot, (cap_slot == LAST_SLOT), shift_d};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= SYNC;
            bit_q       <= '0;
            slot_q      <= '0;
            done_q      <= 1'b0;
            shift_q     <= '0;
            push_q      <= 1'b0;
            push_data_q <= '0;
        end else begin
            state_q     <= state_d;
            bit_q       <= bit_d;
            slot_q      <= slot_d;
            done_q      <= done_d;
            shift_q     <= shift_d;
            push_q      <= push_d;
            push_data_q <= push_data_d;
        end
    end

`ifdef I2S_RX_FRAME_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err_q <= 1'b0;
        else        err_q <= err_d;
    end
    assign frame_err = err_q;
`else
    assign frame_err = 1'b0;
`endif

    logic               fifo_full, fifo_empty;
    logic [ENTRY_W-1:0] fifo_rd;
    logic               ovf_q, ovf_d;

    sample_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_i      (push_q),
        .wr_data_i (push_data_q),
        .rd_i      (m_ok),
        .rd_data_o (fifo_rd),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign m_vld                     = ~fifo_empty;
    assign {m_slot, m_last, m_data}  = fifo_rd;

    // A pop in the same cycle makes room, so only a push against a full, unread FIFO is a drop.
    assign ovf_d = ovf_clr ? 1'b0 : (ovf_q | (push_q & fifo_full & ~m_ok));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ovf_q <= 1'b0;
        else        ovf_q <= ovf_d;
    end
    assign ovf = ovf_q;
endmodule

// File: tb/tb_i2s_rx_tdm.sv
// Directed bench: stereo I2S 24/32 instance plus an 8-slot left-justified 16/32 TDM instance.
`timescale 1ns/1ps
module tb_i2s_rx_tdm;
    typedef struct packed {
        logic [3:0]  slot;
        logic        last;
        logic [23:0] data;
    } rec_t;

    typedef struct {
        logic [31:0] wl;
        logic [31:0] wr;
        logic [23:0] el;
        logic [23:0] er;
    } vec_t;

`ifdef I2S_RX_FRAME_CHECK_EN
    localparam int FERR_EXP = 1;
`else
    localparam int FERR_EXP = 0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic sclk_a = 1'b0, lrck_a = 1'b1, sdi_a = 1'b0;
    logic sclk_b = 1'b0, lrck_b = 1'b0, sdi_b = 1'b0;
    logic m_ok = 1'b0, ovf_clr = 1'b0;
    int   ok_mode = 0;

    logic [23:0] a_data;
    logic [0:0]  a_slot;
    logic        a_last, a_vld, a_ovf, a_ferr;
    logic [15:0] b_data;
    logic [2:0]  b_slot;
    logic        b_last, b_vld, b_ovf, b_ferr;

    rec_t qa[$];
    rec_t qb[$];
    rec_t a_prev;
    logic a_hold = 1'b0;
    int   ferr_cnt = 0;
    int   hold_viol = 0;
    int   pass_cnt = 0;
    int   total_cnt = 0;

    always #5 clk = ~clk;

    i2s_rx_tdm u_dut (
        .clk(clk), .rst_n(rst_n), .sclk(sclk_a), .lrck(lrck_a), .sdi(sdi_a),
        .m_data(a_data), .m_slot(a_slot), .m_last(a_last), .m_vld(a_vld), .m_ok(m_ok),
        .ovf(a_ovf), .ovf_clr(ovf_clr), .frame_err(a_ferr)
    );

    i2s_rx_tdm #(
        .SAMPLE_WIDTH(16), .SLOT_WIDTH(32), .NUM_SLOTS(8), .FMT_LJ(1), .FIFO_DEPTH(8)
    ) u_tdm (
        .clk(clk), .rst_n(rst_n), .sclk(sclk_b), .lrck(lrck_b), .sdi(sdi_b),
        .m_data(b_data), .m_slot(b_slot), .m_last(b_last), .m_vld(b_vld), .m_ok(m_ok),
        .ovf(b_ovf), .ovf_clr(ovf_clr), .frame_err(b_ferr)
    );

    function automatic rec_t mk(input logic [3:0] s, input logic l, input logic [23:0] d);
        rec_t r;
        r.slot = s;
        r.last = l;
        r.data = d;
        return r;
    endfunction

    function automatic rec_t get_a(input int i);
        if (i < qa.size()) return qa[i];
        return 'x;
    endfunction

    function automatic rec_t get_b(input int i);
        if (i < qb.size()) return qb[i];
        return 'x;
    endfunction

    // Consumer handshake driver
    initial begin
        forever begin
            @(posedge clk);
            #1;
            m_ok = (ok_mode == 2) ? 1'($urandom_range(0, 1)) : (ok_mode == 1);
        end
    end

    // Transfer monitor, sampled on the falling edge
    always @(negedge clk) begin
        if (rst_n) begin
            if (a_vld && m_ok) qa.push_back(mk(4'(a_slot), a_last, a_data));
            if (b_vld && m_ok) qb.push_back(mk(4'(b_slot), b_last, {8'h00, b_data}));
            if (a_ferr) ferr_cnt++;
            if (a_hold && a_vld && (mk(4'(a_slot), a_last, a_data) != a_prev)) hold_viol++;
            a_hold = a_vld && !m_ok;
            a_prev = mk(4'(a_slot), a_last, a_data);
        end else begin
            a_hold = 1'b0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bit_a(input logic l, input logic d);
        sclk_a = 1'b0; lrck_a = l; sdi_a = d;
        #20;
        sclk_a = 1'b1;
        #20;
    endtask

    task automatic bit_b(input logic l, input logic d);
        sclk_b = 1'b0; lrck_b = l; sdi_b = d;
        #20;
        sclk_b = 1'b1;
        #20;
    endtask

    // Stereo I2S frame: lrck low for the left slot, data one sclk behind lrck.
    task automatic send_frame_a(input logic [31:0] wl, input logic [31:0] wr, input int len, input int rst_pos);
        for (int j = 0; j < len; j++) begin
            int          p;
            logic [31:0] w;
            logic        d;
            p = j - 1;
            w = (p >= 32) ? wr : wl;
            d = 1'b0;
            if (p >= 0) d = w[31 - (p % 32)];
            if (j == rst_pos) rst_n = 1'b0;
            bit_a(j >= 32, d);
            rst_n = 1'b1;
        end
    endtask

    // LJ TDM frame: one-bit frame-sync pulse, slot k carries 0x1000+k over 16 bits of ones padding.
    task automatic send_tdm_frame();
        for (int j = 0; j < 256; j++) begin
            logic [31:0] w;
            w = {16'h1000 + 16'(j / 32), 16'hFFFF};
            bit_b(j == 0, w[31 - (j % 32)]);
        end
    endtask

    initial begin
        vec_t        vecs[4];
        rec_t        exp_q[$];
        rec_t        r;
        logic [31:0] wl, wr;
        logic [23:0] s;
        int          base, mism;

        vecs[0] = '{32'h12345600, 32'hABCDEF00, 24'h123456, 24'hABCDEF};
        vecs[1] = '{32'h800000FF, 32'h7FFFFFAA, 24'h800000, 24'h7FFFFF};
        vecs[2] = '{32'hFFFFFFFF, 32'h00000001, 24'hFFFFFF, 24'h000000};
        vecs[3] = '{32'hA5A5A5A5, 32'h5A5A5A5A, 24'hA5A5A5, 24'h5A5A5A};

        rst_n = 1'b0;
        wait_clk(3);
        check("rst_vld", a_vld, 0);
        check("rst_data", a_data, 0);
        check("rst_slot", a_slot, 0);
        check("rst_last", a_last, 0);
        check("rst_ovf", a_ovf, 0);
        check("rst_ferr", a_ferr, 0);
        rst_n = 1'b1;
        wait_clk(3);
        check("post_rst_vld", a_vld, 0);

        // TDM, left-justified, 8 slots
        ok_mode = 1;
        wait_clk(2);
        repeat (4) bit_b(1'b0, 1'b0);
        send_tdm_frame();
        repeat (4) bit_b(1'b0, 1'b0);
        wait_clk(10);
        check("tdm_count", qb.size(), 8);
        for (int k = 0; k < 8; k++) begin
            r = get_b(k);
            check($sformatf("tdm_data%0d", k), r.data, 32'h1000 + k);
            check($sformatf("tdm_slot%0d", k), r.slot, k);
            check($sformatf("tdm_last%0d", k), r.last, (k == 7));
        end
        check("tdm_ovf", b_ovf, 0);

        // Stereo I2S vector table
        qa.delete();
        repeat (4) bit_a(1'b1, 1'b0);
        for (int v = 0; v < 4; v++) send_frame_a(vecs[v].wl, vecs[v].wr, 64, -1);
        wait_clk(10);
        check("vec_count", qa.size(), 8);
        for (int v = 0; v < 4; v++) begin
            r = get_a(2 * v);
            check($sformatf("vec%0d_l_data", v), r.data, vecs[v].el);
            check($sformatf("vec%0d_l_slot", v), r.slot, 0);
            check($sformatf("vec%0d_l_last", v), r.last, 0);
            r = get_a(2 * v + 1);
            check($sformatf("vec%0d_r_data", v), r.data, vecs[v].er);
            check($sformatf("vec%0d_r_slot", v), r.slot, 1);
            check($sformatf("vec%0d_r_last", v), r.last, 1);
        end

        // Overflow: 12 samples into an 8-deep FIFO with the consumer stalled
        ok_mode = 0;
        wait_clk(2);
        qa.delete();
        for (int k = 0; k < 4; k++) begin
            s = 24'hC00000 + 24'(2 * k);
            wl = {s, 8'h5A};
            s = 24'hC00000 + 24'(2 * k + 1);
            wr = {s, 8'hA5};
            send_frame_a(wl, wr, 64, -1);
        end
        wait_clk(10);
        check("ovf_at_full", a_ovf, 0);
        check("head_at_full", a_data, 24'hC00000);
        for (int k = 4; k < 6; k++) begin
            s = 24'hC00000 + 24'(2 * k);
            wl = {s, 8'h5A};
            s = 24'hC00000 + 24'(2 * k + 1);
            wr = {s, 8'hA5};
            send_frame_a(wl, wr, 64, -1);
        end
        wait_clk(10);
        check("ovf_set", a_ovf, 1);
        check("head_after_drop", a_data, 24'hC00000);
        check("vld_held", a_vld, 1);
        ok_mode = 1;
        wait_clk(20);
        check("ovf_kept", qa.size(), 8);
        for (int k = 0; k < 8; k++) begin
            r = get_a(k);
            check($sformatf("ovf_data%0d", k), r.data, 24'hC00000 + k);
            check($sformatf("ovf_slot%0d", k), r.slot, k % 2);
        end
        check("ovf_sticky", a_ovf, 1);
        ovf_clr = 1'b1;
        wait_clk(1);
        ovf_clr = 1'b0;
        wait_clk(1);
        check("ovf_clr", a_ovf, 0);

        // Reset at slot 0 bit 10 (data position 11)
        qa.delete();
        send_frame_a(32'h11111100, 32'h22222200, 64, 11);
        send_frame_a(32'h33333300, 32'h44444400, 64, -1);
        wait_clk(10);
        check("rstmid_count", qa.size(), 2);
        r = get_a(0);
        check("rstmid_first", r.data, 24'h333333);
        check("rstmid_first_slot", r.slot, 0);
        r = get_a(1);
        check("rstmid_second", r.data, 24'h444444);

        // Early frame edge at slot 1 bit 5
        qa.delete();
        base = ferr_cnt;
        send_frame_a(32'h55555500, 32'h66666600, 38, -1);
        send_frame_a(32'h77777700, 32'h88888800, 64, -1);
        wait_clk(10);
        check("ferr_pulses", ferr_cnt - base, FERR_EXP);
        check("ferr_count", qa.size(), 3);
        r = get_a(0);
        check("ferr_s0", r.data, 24'h555555);
        r = get_a(1);
        check("ferr_next_l", r.data, 24'h777777);
        check("ferr_next_l_slot", r.slot, 0);
        r = get_a(2);
        check("ferr_next_r", r.data, 24'h888888);
        check("ferr_next_r_last", r.last, 1);

        // Random consumer throttling over 100 frames
        qa.delete();
        ok_mode = 2;
        for (int f = 0; f < 100; f++) begin
            wl = $urandom;
            wr = $urandom;
            exp_q.push_back(mk(4'd0, 1'b0, wl[31:8]));
            exp_q.push_back(mk(4'd1, 1'b1, wr[31:8]));
            send_frame_a(wl, wr, 64, -1);
        end
        ok_mode = 1;
        wait_clk(20);
        check("rand_count", qa.size(), exp_q.size());
        mism = 0;
        for (int i = 0; i < exp_q.size(); i++) begin
            r = get_a(i);
            if (r !== exp_q[i]) mism++;
        end
        check("rand_seq_mismatches", mism, 0);
        check("rand_ovf", a_ovf, 0);
        check("hold_stable_violations", hold_viol, 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
